writeback_stage: RTL and testbench



---
 rtl/writeback_pkg.sv | 15 +
 rtl/writeback_if.sv | 38 +++
 rtl/wb_load_fifo.sv | 59 +++++
 rtl/writeback_stage.sv | 93 +++++++++
 tb/tb_writeback_stage.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/writeback_pkg.sv
// Shared types for the register-file writeback stage.
package writeback_pkg;

   typedef logic [0:63] word_t;
   typedef logic [0:4]  reg_addr_t;
   typedef logic [0:3]  flags_t;

   localparam reg_addr_t FLAGS_REG = 5'd30;

   typedef struct packed {
      reg_addr_t addr;
      word_t     data;
   } ld_entry_t;

endpackage

// File: rtl/writeback_if.sv
// ALU/load result inputs and register-file write port of the writeback stage.
interface writeback_if;
   import writeback_pkg::*;

   logic      alu_valid;
   logic      alu_ready;
   reg_addr_t alu_addr;
   word_t     alu_data;
   logic      alu_setflags;
   flags_t    alu_flags;

   logic      ld_valid;
   logic      ld_ready;
   reg_addr_t ld_addr;
   word_t     ld_data;

   logic [0:0] write_enable;
   reg_addr_t  write_addr;
   word_t      write_data;
   logic       setflags;
   flags_t     flags;
   logic       ld_pending;

   modport slave (
      input  alu_valid, alu_addr, alu_data, alu_setflags, alu_flags,
      input  ld_valid, ld_addr, ld_data,
      output alu_ready, ld_ready,
      output write_enable, write_addr, write_data, setflags, flags, ld_pending
   );

   modport master (
      output alu_valid, alu_addr, alu_data, alu_setflags, alu_flags,
      output ld_valid, ld_addr, ld_data,
      input  alu_ready, ld_ready,
      input  write_enable, write_addr, write_data, setflags, flags, ld_pending
   );

endinterface

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO buffering load results until they win the write port.
module wb_load_fifo
   import writeback_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  ld_entry_t              push_data,
   input  logic                   pop,
   output ld_entry_t              pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   ld_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (PTR_W+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// Arbitrates ALU and buffered load results onto the single register-file write port;
// ALU wins unless it has held the port MAX_ALU_STREAK times while a load waits.
module writeback_stage
   import writeback_pkg::*;
#(
   parameter int LD_FIFO_DEPTH  = 4,
   parameter int MAX_ALU_STREAK = 3
) (
   input logic        clk,
   input logic        rst,
   writeback_if.slave wb
);

   localparam int STREAK_W = $clog2(MAX_ALU_STREAK + 1);

   ld_entry_t                     ld_entry;
   ld_entry_t                     ld_head;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic [$clog2(LD_FIFO_DEPTH):0] fifo_count;
   logic                          ld_push;
   logic [STREAK_W-1:0]           streak;
   logic                          force_load;
   logic                          alu_grant;
   logic                          ld_grant;
   reg_addr_t                     grant_addr;
   word_t                         grant_data;

   assign ld_entry.addr = wb.ld_addr;
   assign ld_entry.data = wb.ld_data;
   assign ld_push       = wb.ld_valid && wb.ld_ready;

   wb_load_fifo #(.DEPTH(LD_FIFO_DEPTH)) u_load_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (ld_push),
      .push_data (ld_entry),
      .pop       (ld_grant),
      .pop_data  (ld_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign wb.ld_pending = !fifo_empty;
   assign wb.ld_ready   = !fifo_full;
   assign force_load    = wb.ld_pending && (streak == STREAK_W'(MAX_ALU_STREAK));
   assign wb.alu_ready  = !force_load;
   assign alu_grant     = wb.alu_valid && wb.alu_ready;
   assign ld_grant      = wb.ld_pending && !alu_grant;

   always_comb begin
      grant_addr = ld_head.addr;
      grant_data = ld_head.data;
      if (alu_grant) begin
         grant_addr = wb.alu_addr;
         grant_data = wb.alu_data;
      end
   end

   // Streak only counts ALU wins that actually made a load wait.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         streak <= '0;
      end else if (!wb.ld_pending || ld_grant) begin
         streak <= '0;
      end else if (alu_grant && (streak != STREAK_W'(MAX_ALU_STREAK))) begin
         streak <= streak + STREAK_W'(1);
      end
   end

   // Register 30 is owned by flags; data writes to it are accepted and dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb.write_enable <= '0;
         wb.write_addr   <= '0;
         wb.write_data   <= '0;
         wb.setflags     <= 1'b0;
         wb.flags        <= '0;
      end else begin
         wb.write_enable <= 1'((alu_grant || ld_grant) && (grant_addr != FLAGS_REG));
         if (alu_grant || ld_grant) begin
            wb.write_addr <= grant_addr;
            wb.write_data <= grant_data;
         end
         wb.setflags <= alu_grant && wb.alu_setflags;
         if (alu_grant && wb.alu_setflags) begin
            wb.flags <= wb.alu_flags;
         end
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized and directed bench for writeback_stage against a queue-based reference model.
module tb_writeback_stage;
   import writeback_pkg::*;

   localparam int DEPTH = 4;
   localparam int MAXS  = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   writeback_if wb();

   writeback_stage #(.LD_FIFO_DEPTH(DEPTH), .MAX_ALU_STREAK(MAXS)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb.slave)
   );

   int checks   = 0;
   int failures = 0;

   ld_entry_t q[$];
   int        streak;
   logic      exp_we;
   reg_addr_t exp_waddr;
   word_t     exp_wdata;
   logic      exp_sf;
   flags_t    exp_flags;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check_val("alu_ready", 64'(wb.alu_ready), 64'(!(q.size() > 0 && streak == MAXS)));
      check_val("ld_ready", 64'(wb.ld_ready), 64'(q.size() != DEPTH));
      check_val("ld_pending", 64'(wb.ld_pending), 64'(q.size() > 0));
      check_val("write_enable", 64'(wb.write_enable), 64'(exp_we));
      check_val("write_addr", 64'(wb.write_addr), 64'(exp_waddr));
      check_val("write_data", wb.write_data, exp_wdata);
      check_val("setflags", 64'(wb.setflags), 64'(exp_sf));
      check_val("flags", 64'(wb.flags), 64'(exp_flags));
   endtask

   task automatic model_clear();
      q.delete();
      streak    = 0;
      exp_we    = 1'b0;
      exp_waddr = '0;
      exp_wdata = '0;
      exp_sf    = 1'b0;
      exp_flags = '0;
   endtask

   // One cycle: check current outputs, drive inputs, predict the next posedge.
   task automatic step(input logic av, input reg_addr_t aa, input word_t ad, input logic asf,
                       input flags_t af, input logic lv, input reg_addr_t la, input word_t ldd);
      bit        ready_a, ag, lg, push, pending;
      ld_entry_t e;
      @(negedge clk);
      check_outputs();
      wb.alu_valid    = av;
      wb.alu_addr     = aa;
      wb.alu_data     = ad;
      wb.alu_setflags = asf;
      wb.alu_flags    = af;
      wb.ld_valid     = lv;
      wb.ld_addr      = la;
      wb.ld_data      = ldd;
      pending = q.size() > 0;
      ready_a = !(pending && streak == MAXS);
      ag      = av && ready_a;
      lg      = pending && !ag;
      push    = lv && (q.size() != DEPTH);
      if (!pending || lg) streak = 0;
      else if (ag && streak < MAXS) streak++;
      exp_sf = ag && asf;
      if (exp_sf) exp_flags = af;
      if (ag) begin
         exp_we    = (aa != FLAGS_REG);
         exp_waddr = aa;
         exp_wdata = ad;
      end else if (lg) begin
         e         = q.pop_front();
         exp_we    = (e.addr != FLAGS_REG);
         exp_waddr = e.addr;
         exp_wdata = e.data;
      end else begin
         exp_we = 1'b0;
      end
      if (push) begin
         e.addr = la;
         e.data = ldd;
         q.push_back(e);
      end
   endtask

   task automatic idle();
      step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      wb.alu_valid = 1'b0;
      wb.ld_valid  = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_val("rst_write_enable", 64'(wb.write_enable), 64'd0);
      check_val("rst_write_addr", 64'(wb.write_addr), 64'd0);
      check_val("rst_write_data", wb.write_data, 64'd0);
      check_val("rst_setflags", 64'(wb.setflags), 64'd0);
      check_val("rst_flags", 64'(wb.flags), 64'd0);
      check_val("rst_ld_pending", 64'(wb.ld_pending), 64'd0);
      model_clear();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic random_cycle();
      reg_addr_t aa, la;
      aa = ($urandom_range(0, 5) == 0) ? FLAGS_REG : 5'($urandom_range(0, 31));
      la = ($urandom_range(0, 7) == 0) ? FLAGS_REG : 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 9) < 6), aa, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), la, {$urandom, $urandom});
   endtask

   initial begin
      rst             = 1'b1;
      wb.alu_valid    = 1'b0;
      wb.alu_addr     = '0;
      wb.alu_data     = '0;
      wb.alu_setflags = 1'b0;
      wb.alu_flags    = '0;
      wb.ld_valid     = 1'b0;
      wb.ld_addr      = '0;
      wb.ld_data      = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Flag-setting ALU write, then idle: flags must hold.
      step(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b1, 4'b1010, 1'b0, '0, '0);
      @(posedge clk);
      #1;
      check_val("dir_alu_we", 64'(wb.write_enable), 64'd1);
      check_val("dir_alu_data", wb.write_data, 64'hDEAD_BEEF);
      check_val("dir_alu_flags", 64'(wb.flags), 64'b1010);
      idle();
      idle();

      // Data write to the flags register is accepted but dropped.
      step(1'b1, FLAGS_REG, 64'h1234, 1'b0, 4'b0101, 1'b0, '0, '0);
      @(posedge clk);
      #1;
      check_val("dir_r30_we", 64'(wb.write_enable), 64'd0);
      check_val("dir_r30_flags", 64'(wb.flags), 64'b1010);
      idle();

      // Back-to-back loads with no ALU traffic.
      for (int i = 1; i <= 5; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'(i), 64'(i * 16));
      repeat (4) idle();

      // One buffered load versus a continuous ALU stream forces the load after the streak.
      step(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd9, 64'h99);
      for (int i = 0; i < 8; i++) step(1'b1, 5'(10 + i), 64'(i), 1'b0, '0, 1'b0, '0, '0);
      idle();

      // ALU stream while loads pile up fills the FIFO and drops ld_ready.
      for (int i = 0; i < 14; i++)
         step(1'b1, 5'(i), 64'(100 + i), 1'b0, '0, 1'b1, 5'(20 - i), 64'(200 + i));
      repeat (6) idle();

      // Reset mid-stream with loads buffered.
      step(1'b1, 5'd3, 64'h33, 1'b0, '0, 1'b1, 5'd1, 64'h11);
      step(1'b1, 5'd4, 64'h44, 1'b1, 4'b1111, 1'b1, 5'd2, 64'h22);
      apply_reset();
      repeat (3) idle();

      for (int i = 0; i < 800; i++) random_cycle();
      repeat (8) idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
